// File: rtl/sodor5_commit_checker_pkg.sv
// Shared types and constants for the sodor5 lockstep commit checker.
package sodor5_verif_pkg;

   localparam int unsigned NUM_REGS  = 32;
   localparam int unsigned WORD_SIZE = 32;
   localparam int unsigned RD_W      = 5;

   localparam logic [RD_W-1:0] X0 = 5'd0;

   typedef struct packed {
      logic [RD_W-1:0]      rd;
      logic [WORD_SIZE-1:0] data;
   } commit_entry_t;

endpackage

// File: rtl/sodor5_commit_checker_if.sv
// Writeback event bundle from the core (dut_*) and the reference model (mdl_*).
interface sodor5_commit_checker_if #(
   parameter int unsigned XLEN = 32
);
   logic            dut_wb_valid;
   logic [4:0]      dut_wb_rd;
   logic [XLEN-1:0] dut_wb_data;
   logic            mdl_wb_valid;
   logic [4:0]      mdl_wb_rd;
   logic [XLEN-1:0] mdl_wb_data;

   modport master (
      output dut_wb_valid, dut_wb_rd, dut_wb_data,
      output mdl_wb_valid, mdl_wb_rd, mdl_wb_data
   );

   modport slave (
      input dut_wb_valid, dut_wb_rd, dut_wb_data,
      input mdl_wb_valid, mdl_wb_rd, mdl_wb_data
   );
endinterface

// File: rtl/sodor5_commit_fifo.sv
// Synchronous FIFO of commit entries; a push into a full FIFO lands only if the head pops that cycle.
module sodor5_commit_fifo
   import sodor5_verif_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  commit_entry_t push_entry,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output commit_entry_t head
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   commit_entry_t mem [DEPTH];
   logic          do_pop;
   logic          do_push;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + PW'(1);
         if (do_pop)  rptr <= rptr + PW'(1);
      end
   end

   // Storage carries no reset; occupancy is defined purely by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= push_entry;
   end

endmodule

// File: rtl/sodor5_commit_checker.sv
// In-order retirement comparator: buffers core and model writebacks, pairs them and flags divergence.
module sodor5_commit_checker
   import sodor5_verif_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned MAX_LAG = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   sodor5_commit_checker_if.slave  wb,
   output logic                    mismatch,
   output logic                    overflow,
   output logic                    timeout,
   output logic [31:0]             fail_idx,
   output logic [4:0]              fail_dut_rd,
   output logic [XLEN-1:0]         fail_dut_data,
   output logic [4:0]              fail_mdl_rd,
   output logic [XLEN-1:0]         fail_mdl_data,
   output logic [31:0]             commit_count
);
   localparam int unsigned LW = $clog2(MAX_LAG + 1);

   logic          dut_push, mdl_push;
   logic          dut_full, mdl_full;
   logic          dut_empty, mdl_empty;
   commit_entry_t dut_entry, mdl_entry;
   commit_entry_t dut_head, mdl_head;
   logic          pop_both;
   logic          one_sided;
   logic          drop;

   logic          cmp_valid;
   commit_entry_t cmp_dut, cmp_mdl;
   logic [LW-1:0] lag;

   // x0 writes are architecturally void and never enter the FIFOs.
   assign dut_push  = wb.dut_wb_valid && (wb.dut_wb_rd != X0);
   assign mdl_push  = wb.mdl_wb_valid && (wb.mdl_wb_rd != X0);
   assign dut_entry = '{rd: wb.dut_wb_rd, data: WORD_SIZE'(wb.dut_wb_data)};
   assign mdl_entry = '{rd: wb.mdl_wb_rd, data: WORD_SIZE'(wb.mdl_wb_data)};

   assign pop_both  = !dut_empty && !mdl_empty;
   assign one_sided = dut_empty ^ mdl_empty;
   assign drop      = (dut_push && dut_full && !pop_both) ||
                      (mdl_push && mdl_full && !pop_both);

   sodor5_commit_fifo #(.DEPTH(DEPTH)) u_dut_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (dut_push),
      .push_entry (dut_entry),
      .pop        (pop_both),
      .full       (dut_full),
      .empty      (dut_empty),
      .head       (dut_head)
   );

   sodor5_commit_fifo #(.DEPTH(DEPTH)) u_mdl_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (mdl_push),
      .push_entry (mdl_entry),
      .pop        (pop_both),
      .full       (mdl_full),
      .empty      (mdl_empty),
      .head       (mdl_head)
   );

   // Popped pair is registered; compare result and snapshot land one edge later.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmp_valid     <= 1'b0;
         cmp_dut       <= '0;
         cmp_mdl       <= '0;
         mismatch      <= 1'b0;
         fail_idx      <= '0;
         fail_dut_rd   <= '0;
         fail_dut_data <= '0;
         fail_mdl_rd   <= '0;
         fail_mdl_data <= '0;
         commit_count  <= '0;
      end else begin
         cmp_valid <= pop_both;
         if (pop_both) begin
            cmp_dut <= dut_head;
            cmp_mdl <= mdl_head;
         end
         if (cmp_valid) begin
            commit_count <= commit_count + 32'd1;
            if ((cmp_dut != cmp_mdl) && !mismatch) begin
               mismatch      <= 1'b1;
               fail_idx      <= commit_count;
               fail_dut_rd   <= cmp_dut.rd;
               fail_dut_data <= XLEN'(cmp_dut.data);
               fail_mdl_rd   <= cmp_mdl.rd;
               fail_mdl_data <= XLEN'(cmp_mdl.data);
            end
         end
      end
   end

   // Sticky overflow and a saturating lag counter driving the sticky timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
         timeout  <= 1'b0;
         lag      <= '0;
      end else begin
         if (drop) overflow <= 1'b1;
         if (one_sided) begin
            if (lag != LW'(MAX_LAG)) lag <= lag + LW'(1);
         end else begin
            lag <= '0;
         end
         if (lag == LW'(MAX_LAG)) timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sodor5_commit_checker.sv
// Directed bench for sodor5_commit_checker: vector table plus overflow/timeout and mid-stream reset sequences.
module tb_sodor5_commit_checker;
   import sodor5_verif_pkg::*;

   localparam int unsigned XLEN = 32;

   logic clk = 1'b0;
   logic reset;

   logic            mismatch, overflow, timeout;
   logic [31:0]     fail_idx, commit_count;
   logic [4:0]      fail_dut_rd, fail_mdl_rd;
   logic [XLEN-1:0] fail_dut_data, fail_mdl_data;

   int checks = 0;
   int errors = 0;

   sodor5_commit_checker_if #(.XLEN(XLEN)) wb ();

   sodor5_commit_checker #(.XLEN(XLEN), .DEPTH(8), .MAX_LAG(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .wb            (wb.slave),
      .mismatch      (mismatch),
      .overflow      (overflow),
      .timeout       (timeout),
      .fail_idx      (fail_idx),
      .fail_dut_rd   (fail_dut_rd),
      .fail_dut_data (fail_dut_data),
      .fail_mdl_rd   (fail_mdl_rd),
      .fail_mdl_data (fail_mdl_data),
      .commit_count  (commit_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        dv;
      logic [4:0]  drd;
      logic [31:0] dd;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] md;
      logic        e_mis;
      logic        e_ovf;
      logic        e_to;
      logic [31:0] e_cc;
      logic [31:0] e_idx;
      logic [4:0]  e_drd;
      logic [31:0] e_dd;
      logic [4:0]  e_mrd;
      logic [31:0] e_md;
   } vec_t;

   vec_t vecs [25];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge: drive inputs, let one rising edge pass, return at the following negedge.
   task automatic step(input logic rst, input logic dv, input logic [4:0] drd, input logic [31:0] dd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
      reset           = rst;
      wb.dut_wb_valid = dv;
      wb.dut_wb_rd    = drd;
      wb.dut_wb_data  = dd;
      wb.mdl_wb_valid = mv;
      wb.mdl_wb_rd    = mrd;
      wb.mdl_wb_data  = md;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   function automatic vec_t mk(input logic rst, input logic dv, input logic [4:0] drd, input logic [31:0] dd,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                               input logic e_mis, input logic [31:0] e_cc,
                               input logic [31:0] e_idx, input logic [4:0] e_drd, input logic [31:0] e_dd,
                               input logic [4:0] e_mrd, input logic [31:0] e_md);
      vec_t v;
      v.rst = rst; v.dv = dv; v.drd = drd; v.dd = dd; v.mv = mv; v.mrd = mrd; v.md = md;
      v.e_mis = e_mis; v.e_ovf = 1'b0; v.e_to = 1'b0; v.e_cc = e_cc;
      v.e_idx = e_idx; v.e_drd = e_drd; v.e_dd = e_dd; v.e_mrd = e_mrd; v.e_md = e_md;
      return v;
   endfunction

   initial begin
      reset = 1'b1;
      wb.dut_wb_valid = 1'b0; wb.dut_wb_rd = '0; wb.dut_wb_data = '0;
      wb.mdl_wb_valid = 1'b0; wb.mdl_wb_rd = '0; wb.mdl_wb_data = '0;

      // Lockstep match.
      vecs[0]  = mk(1, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 1, 4, 0,            1, 4, 0,            0, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 1, 5, 0,            1, 5, 0,            0, 0, 0, 0, 0, 0, 0);
      vecs[3]  = mk(0, 0, 0, 0,            0, 0, 0,            0, 1, 0, 0, 0, 0, 0);
      vecs[4]  = mk(0, 0, 0, 0,            0, 0, 0,            0, 2, 0, 0, 0, 0, 0);
      // Skewed: model lags the core by three cycles.
      vecs[5]  = mk(1, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0, 0);
      vecs[6]  = mk(0, 1, 3, 32'h88888888, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0);
      vecs[7]  = mk(0, 1, 3, 32'h12,       0, 0, 0,            0, 0, 0, 0, 0, 0, 0);
      vecs[8]  = mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0, 0);
      vecs[9]  = mk(0, 0, 0, 0,            1, 3, 32'h88888888, 0, 0, 0, 0, 0, 0, 0);
      vecs[10] = mk(0, 0, 0, 0,            1, 3, 32'h12,       0, 0, 0, 0, 0, 0, 0);
      vecs[11] = mk(0, 0, 0, 0,            0, 0, 0,            0, 1, 0, 0, 0, 0, 0);
      vecs[12] = mk(0, 0, 0, 0,            0, 0, 0,            0, 2, 0, 0, 0, 0, 0);
      // Data mismatch at pair index 2, then a later bad pair that must not overwrite the snapshot.
      vecs[13] = mk(1, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0, 0);
      vecs[14] = mk(0, 1, 1, 1,            1, 1, 1,            0, 0, 0, 0, 0, 0, 0);
      vecs[15] = mk(0, 1, 2, 2,            1, 2, 2,            0, 0, 0, 0, 0, 0, 0);
      vecs[16] = mk(0, 1, 4, 0,            1, 4, 1,            0, 1, 0, 0, 0, 0, 0);
      vecs[17] = mk(0, 1, 7, 32'hAA,       1, 8, 32'hBB,       0, 2, 0, 0, 0, 0, 0);
      vecs[18] = mk(0, 0, 0, 0,            0, 0, 0,            1, 3, 2, 4, 0, 4, 1);
      vecs[19] = mk(0, 0, 0, 0,            0, 0, 0,            1, 4, 2, 4, 0, 4, 1);
      // x0 filter.
      vecs[20] = mk(1, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0, 0);
      vecs[21] = mk(0, 1, 0, 32'hDEAD,     0, 0, 0,            0, 0, 0, 0, 0, 0, 0);
      vecs[22] = mk(0, 1, 6, 32'h66,       1, 6, 32'h66,       0, 0, 0, 0, 0, 0, 0);
      vecs[23] = mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 0, 0);
      vecs[24] = mk(0, 0, 0, 0,            0, 0, 0,            0, 1, 0, 0, 0, 0, 0);

      @(negedge clk);
      for (int i = 0; i < 25; i++) begin
         step(vecs[i].rst, vecs[i].dv, vecs[i].drd, vecs[i].dd, vecs[i].mv, vecs[i].mrd, vecs[i].md);
         chk($sformatf("v%0d.mismatch", i),      64'(mismatch),      64'(vecs[i].e_mis));
         chk($sformatf("v%0d.overflow", i),      64'(overflow),      64'(vecs[i].e_ovf));
         chk($sformatf("v%0d.timeout", i),       64'(timeout),       64'(vecs[i].e_to));
         chk($sformatf("v%0d.commit_count", i),  64'(commit_count),  64'(vecs[i].e_cc));
         chk($sformatf("v%0d.fail_idx", i),      64'(fail_idx),      64'(vecs[i].e_idx));
         chk($sformatf("v%0d.fail_dut_rd", i),   64'(fail_dut_rd),   64'(vecs[i].e_drd));
         chk($sformatf("v%0d.fail_dut_data", i), 64'(fail_dut_data), 64'(vecs[i].e_dd));
         chk($sformatf("v%0d.fail_mdl_rd", i),   64'(fail_mdl_rd),   64'(vecs[i].e_mrd));
         chk($sformatf("v%0d.fail_mdl_data", i), 64'(fail_mdl_data), 64'(vecs[i].e_md));
      end

      // Overflow and timeout: model silent while the core pushes nine entries into an 8-deep FIFO.
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      for (int k = 1; k <= 9; k++) begin
         step(1'b0, 1'b1, 5'(k), 32'(k * 16), 1'b0, 5'd0, 32'd0);
         if (k == 8) chk("ovf.before_9th", 64'(overflow), 64'd0);
      end
      chk("ovf.after_9th", 64'(overflow), 64'd1);
      chk("to.early", 64'(timeout), 64'd0);
      begin
         int waited = 0;
         while (!timeout && waited < 40) begin
            idle();
            waited++;
         end
         chk("to.set_within_budget", 64'(timeout), 64'd1);
         chk("to.not_too_early", 64'(waited >= 5), 64'd1);
      end
      idle();
      chk("to.sticky", 64'(timeout), 64'd1);
      chk("ovf.sticky", 64'(overflow), 64'd1);
      chk("ovf.no_commits", 64'(commit_count), 64'd0);
      chk("ovf.no_mismatch", 64'(mismatch), 64'd0);

      // Reset mid-stream with a mismatch latched and entries buffered.
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      step(1'b0, 1'b1, 5'd1, 32'd1, 1'b1, 5'd1, 32'd2);
      idle();
      idle();
      chk("rst.pre_mismatch", 64'(mismatch), 64'd1);
      step(1'b0, 1'b1, 5'd11, 32'h11, 1'b0, 5'd0, 32'd0);
      step(1'b0, 1'b1, 5'd12, 32'h12, 1'b0, 5'd0, 32'd0);
      step(1'b0, 1'b1, 5'd13, 32'h13, 1'b0, 5'd0, 32'd0);
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("rst.mismatch", 64'(mismatch), 64'd0);
      chk("rst.overflow", 64'(overflow), 64'd0);
      chk("rst.timeout", 64'(timeout), 64'd0);
      chk("rst.commit_count", 64'(commit_count), 64'd0);
      chk("rst.fail_idx", 64'(fail_idx), 64'd0);
      step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h99);
      idle();
      idle();
      chk("post.commit_count", 64'(commit_count), 64'd1);
      chk("post.mismatch", 64'(mismatch), 64'd0);
      step(1'b0, 1'b1, 5'd10, 32'h1, 1'b1, 5'd10, 32'h2);
      idle();
      idle();
      chk("post.mismatch2", 64'(mismatch), 64'd1);
      chk("post.fail_idx", 64'(fail_idx), 64'd1);
      chk("post.fail_dut_rd", 64'(fail_dut_rd), 64'd10);
      chk("post.fail_mdl_data", 64'(fail_mdl_data), 64'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
